aes_core_arbiter: RTL and testbench
===================================

# aes_core_arbiter

Shares one iterative `aes_128` core between `NUM_REQ` independent requesters. Requests are granted round-robin. The block registers the winner's block, key and direction, sequences the core's `start`/`done` protocol, and returns the result with the requester's ID on a single response channel with backpressure. It sits between the crypto clients and the core; the core is instantiated alongside it and fed exclusively through this block.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters (≥2).
- `ID_W`, default `$clog2(NUM_REQ)`: width of the response ID.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high. Also drives the core's `rst`.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: per-requester accept, one-hot or zero.
- `req_data` in `NUM_REQ*128`: input block; requester i occupies `[i*128 +: 128]`.
- `req_key` in `NUM_REQ*128`: cipher key, same packing.
- `req_encrypt` in `NUM_REQ`: 1 = encrypt, 0 = decrypt.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_data` out 128: output block.
- `rsp_id` out `ID_W`: index of the originating requester.
- `busy` out 1: high in any state other than IDLE.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_data_in` out 128: registered block to the core.
- `core_key` out 128: registered key to the core.
- `core_encrypt` out 1: registered direction to the core.
- `core_data_out` in 128: core result.
- `core_done` in 1: core done level. It is cleared by the core on the edge that accepts `start`.

## Operation
FSM states:
- **IDLE**
  - If any `req_valid` is high, the arbiter picks grant `g`, the first valid index after `last_grant` cyclically.
  - `req_ready[g]` is high combinationally in this cycle.
  - At the edge: latch `req_data`/`req_key`/`req_encrypt` of `g` into the `core_*` registers, latch `g` into the ID register, set `last_grant <= g`, go to ISSUE.
- **ISSUE**: `core_start = 1` for exactly this cycle → BUSY.
- **BUSY**: when `core_done == 1`, capture `core_data_out` into `rsp_data` → RESP.
- **RESP**: `rsp_valid = 1`. On `rsp_ready` → IDLE.

Rules:
- `req_ready` is 0 in every state except IDLE.
- A valid request that is not granted must hold its `valid` and payload stable; its `valid` is never dropped by this block.
- `core_data_in`, `core_key` and `core_encrypt` stay constant from the IDLE grant edge until the next grant. The core expands the key combinationally and reads `encrypt` every round, so they must not change mid-operation.
- `rsp_data` and `rsp_id` stay stable while `rsp_valid` is high and `rsp_ready` is low.
- Round-robin: after requester k is served, requester k+1 (mod `NUM_REQ`) has highest priority. When only one requester is valid, it is granted regardless of `last_grant`.
- A request with `req_valid` rising while the block is in RESP is not granted before the return to IDLE.
- `core_done` is ignored outside BUSY. The stale `done=1` left by the previous operation is therefore never mistaken for completion.

## Timing
- Reset values:
  - State IDLE; `last_grant = NUM_REQ-1`, so requester 0 wins first.
  - `req_ready = 0`, `rsp_valid = 0`, `rsp_data = 0`, `rsp_id = 0`, `busy = 0`.
  - `core_start = 0`, `core_data_in = 0`, `core_key = 0`, `core_encrypt = 0`.
- Latency, with request handshake at edge H:
  - ISSUE occupies cycle H..H+1 and the core samples `start` at H+1.
  - `core_done` rises after edge H+11.
  - `rsp_valid` is high after edge H+12.
- Throughput: 14 cycles per block when `rsp_ready` is held high (handshake, ISSUE, 11 core cycles, RESP, back to IDLE).
- Reset mid-operation (any state): the block returns to reset values on the next edge. The core is reset simultaneously through the shared `rst`. The in-flight result is discarded and no response is emitted.
- Simultaneous `rsp_ready` and a new `req_valid` in RESP: the response completes and the request is granted in the following IDLE cycle.

## Structure
- `aes_ctl_pkg` holds:
  - constants `AES_BLK_W = 128` and `AES_CORE_LAT = 11` (core cycles from `start` to `done`);
  - the FSM state encoding (IDLE, ISSUE, BUSY, RESP).
- Sub-module `rr_arbiter`:
  - inputs `NUM_REQ` requests, `last_grant` and an enable;
  - outputs a one-hot grant and its binary index;
  - purely combinational. `last_grant` is owned by the top.
- The top contains the FSM, the payload, ID and response registers, and the core-side registers.

## Test plan
- **FIPS-197 C.1 encrypt**
  - Stimulus: requester 0, key `000102030405060708090a0b0c0d0e0f`, data `00112233445566778899aabbccddeeff`, encrypt=1.
  - Response: `rsp_data = 69c4e0d86a7b0430d8cdb78070b4c55a`, `rsp_id = 0`, `rsp_valid` high 12 cycles after the handshake.
- **C.1 decrypt**
  - Stimulus: requester 1, same key, data `69c4e0d86a7b0430d8cdb78070b4c55a`, encrypt=0.
  - Response: `rsp_data = 00112233445566778899aabbccddeeff`, `rsp_id = 1`.
- **Round-robin**
  - Stimulus: both requesters hold `valid` continuously for 4 transactions, requester 0 with FIPS Appendix B data and requester 1 with the C.1 data. Appendix B: key `2b7e151628aed2a6abf7158809cf4f3c`, data `3243f6a8885a308d313198a2e0370734`.
  - Response: `rsp_id` sequence 0,1,0,1; requester 0 returns `3925841d02dc09fbdc118597196a0b32`.
- **Backpressure**
  - Stimulus: `rsp_ready = 0` for 20 cycles after `rsp_valid`.
  - Response: `rsp_data`/`rsp_id` stable, `req_ready` stays 0, no `core_start`. Release completes the transfer and the next grant occurs the cycle after.
- **Reset mid-op**
  - Stimulus: assert `rst` 5 cycles into BUSY.
  - Response: all outputs at reset values next cycle, no `rsp_valid`. A subsequent C.1 request returns the correct ciphertext with `rsp_id = 0`.
- **Stale done**
  - Stimulus: back-to-back requests.
  - Response: the second response never appears earlier than 12 cycles after its handshake.

Source files
------------

// File: rtl/aes_ctl_pkg.sv
// aes_ctl_pkg: shared constants and FSM encoding for the AES core arbiter.
package aes_ctl_pkg;
    localparam int AES_BLK_W = 128;
    localparam int AES_CORE_LAT = 11;
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first valid request after last_grant.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);
    logic [ID_W-1:0] j;
    // Scan from lowest to highest priority so the nearest follower of last_grant wins.
    always_comb begin
        grant = '0;
        grant_idx = '0;
        j = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            j = ID_W'((int'(last_grant) + i) % NUM_REQ);
            if (en && req[j]) begin
                grant = '0;
                grant[j] = 1'b1;
                grant_idx = j;
            end
        end
    end
endmodule

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: round-robin sharing of one iterative aes_128 core between NUM_REQ requesters.
module aes_core_arbiter
    import aes_ctl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*AES_BLK_W-1:0]   req_data,
    input  logic [NUM_REQ*AES_BLK_W-1:0]   req_key,
    input  logic [NUM_REQ-1:0]             req_encrypt,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [AES_BLK_W-1:0]           rsp_data,
    output logic [ID_W-1:0]                rsp_id,
    output logic                           busy,
    output logic                           core_start,
    output logic [AES_BLK_W-1:0]           core_data_in,
    output logic [AES_BLK_W-1:0]           core_key,
    output logic                           core_encrypt,
    input  logic [AES_BLK_W-1:0]           core_data_out,
    input  logic                           core_done
);
    state_t state;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] grant_idx;
    logic [NUM_REQ-1:0] grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req(req_valid),
        .last_grant(last_grant),
        .en(state == IDLE),
        .grant(grant),
        .grant_idx(grant_idx)
    );

    assign req_ready = grant;

    // core_done is only honoured in BUSY, so the level left over from the previous block is harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            rsp_id <= '0;
            busy <= 1'b0;
            core_start <= 1'b0;
            core_data_in <= '0;
            core_key <= '0;
            core_encrypt <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: if (|grant) begin
                    core_data_in <= req_data[int'(grant_idx)*AES_BLK_W +: AES_BLK_W];
                    core_key <= req_key[int'(grant_idx)*AES_BLK_W +: AES_BLK_W];
                    core_encrypt <= req_encrypt[grant_idx];
                    rsp_id <= grant_idx;
                    last_grant <= grant_idx;
                    core_start <= 1'b1;
                    busy <= 1'b1;
                    state <= ISSUE;
                end
                ISSUE: state <= BUSY;
                BUSY: if (core_done) begin
                    rsp_data <= core_data_out;
                    rsp_valid <= 1'b1;
                    state <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb_aes_core_arbiter: directed FIPS-197 vectors through the arbiter with a lookup-table core stand-in.
`timescale 1ns/1ps
module tb_aes_core_arbiter;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 0, rst = 1;
    logic [1:0] req_valid = 0, req_ready, req_encrypt = 0;
    logic [255:0] req_data = 0, req_key = 0;
    logic rsp_valid, rsp_ready = 1, busy, core_start, core_encrypt, core_done;
    logic [127:0] rsp_data, core_data_in, core_key, core_data_out;
    logic [0:0] rsp_id;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    aes_core_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_key(req_key), .req_encrypt(req_encrypt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy), .core_start(core_start), .core_data_in(core_data_in), .core_key(core_key),
        .core_encrypt(core_encrypt), .core_data_out(core_data_out), .core_done(core_done)
    );

    // Core stand-in: known FIPS-197 pairs, done 10 edges after the start edge, cleared on start.
    function automatic logic [127:0] aes_ref(input logic [127:0] k, d, input logic e);
        if (e && k == K1 && d == P1) return C1;
        if (e && k == K2 && d == P2) return C2;
        if (!e && k == K1 && d == C1) return P1;
        if (!e && k == K2 && d == C2) return P2;
        return d ^ k;
    endfunction

    int cnt;
    always @(posedge clk) begin
        if (rst) begin
            core_done <= 0;
            cnt <= 0;
            core_data_out <= 0;
        end else if (core_start) begin
            core_done <= 0;
            cnt <= 10;
            core_data_out <= aes_ref(core_key, core_data_in, core_encrypt);
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) core_done <= 1;
        end
    end

    logic log_en = 0;
    int nrsp = 0;
    logic [127:0] rd [8];
    logic ri [8];
    time rt [8];
    always @(posedge clk) begin
        if (log_en && rsp_valid && rsp_ready && nrsp < 8) begin
            rd[nrsp] <= rsp_data;
            ri[nrsp] <= rsp_id[0];
            rt[nrsp] <= $time;
            nrsp <= nrsp + 1;
        end
    end

    task automatic check(input string tag, input logic [127:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Presents a request and returns at the negedge after its handshake edge.
    task automatic issue(input int r, input logic [127:0] k, d, input logic e);
        int t;
        @(negedge clk);
        req_valid[r] = 1;
        req_key[r*128 +: 128] = k;
        req_data[r*128 +: 128] = d;
        req_encrypt[r] = e;
        #1;
        t = 0;
        while (!req_ready[r] && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("grant", 128'(req_ready), 128'(2'b01 << r));
        @(posedge clk);
        @(negedge clk);
        req_valid[r] = 0;
    endtask

    task automatic await_rsp(input string tag, input logic [127:0] exp, input logic id);
        int n;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 128'(n), 128'(12));
        check({tag, "_data"}, rsp_data, exp);
        check({tag, "_id"}, 128'(rsp_id), 128'(id));
    endtask

    initial begin
        int t;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", 128'({req_ready, rsp_valid, rsp_id, busy, core_start, core_encrypt}), 128'(0));
        check("rst_rsp_data", rsp_data, 0);
        check("rst_core_data", core_data_in, 0);
        check("rst_core_key", core_key, 0);
        rst = 0;

        issue(0, K1, P1, 1);
        check("issue_ctl", 128'({core_start, busy, core_encrypt, req_ready}), 128'(5'b111_00));
        check("issue_data", core_data_in, P1);
        check("issue_key", core_key, K1);
        await_rsp("c1_enc", C1, 0);

        issue(1, K1, C1, 0);
        check("dec_dir", 128'(core_encrypt), 128'(0));
        await_rsp("c1_dec", P1, 1);

        issue(1, K1, C1, 0);
        await_rsp("single_req", P1, 1);

        @(negedge clk);
        log_en = 1;
        req_key = {K1, K2};
        req_data = {P1, P2};
        req_encrypt = 2'b11;
        req_valid = 2'b11;
        t = 0;
        while (nrsp < 4 && t < 200) begin
            @(negedge clk);
            t++;
        end
        req_valid = 0;
        log_en = 0;
        check("rr_count", 128'(nrsp), 128'(4));
        check("rr_ids", 128'({ri[0], ri[1], ri[2], ri[3]}), 128'(4'b0101));
        check("rr_data0", rd[0], C2);
        check("rr_data1", rd[1], C1);
        check("rr_data2", rd[2], C2);
        check("rr_gap1", 128'(rt[1] - rt[0]), 128'(140));
        check("rr_gap2", 128'(rt[2] - rt[1]), 128'(140));
        check("rr_gap3", 128'(rt[3] - rt[2]), 128'(140));

        rsp_ready = 0;
        issue(0, K2, P2, 1);
        await_rsp("bp", C2, 0);
        req_key[255:128] = K1;
        req_data[255:128] = C1;
        req_encrypt[1] = 0;
        req_valid[1] = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check("bp_data", rsp_data, C2);
            check("bp_ctl", 128'({rsp_valid, rsp_id, req_ready, core_start}), 128'(5'b1_0_00_0));
        end
        rsp_ready = 1;
        @(negedge clk);
        #1;
        check("bp_release", 128'({rsp_valid, req_ready}), 128'(3'b0_10));
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 0;
        check("bp_next_start", 128'(core_start), 128'(1));
        await_rsp("bp_next", P1, 1);

        issue(0, K1, P1, 1);
        repeat (5) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("mid_rst_ctl", 128'({req_ready, rsp_valid, rsp_id, busy, core_start, core_encrypt}), 128'(0));
        check("mid_rst_rsp", rsp_data, 0);
        check("mid_rst_core", {core_data_in ^ core_key}, 0);
        check("mid_rst_key", core_key, 0);
        t = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) t++;
        end
        check("mid_rst_no_rsp", 128'(t), 128'(0));
        issue(0, K1, P1, 1);
        await_rsp("post_rst", C1, 0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
